// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed big-endian byte stream into instruction memory while holding the CPU in reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int size    = 32,
    parameter int MemSize = 512,
    parameter int AW      = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            load_req,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [size-1:0] imem_wdata,
    output logic            cpu_reset,
    output logic            done,
    output logic [1:0]      err_code,
    output logic [AW:0]     words_loaded
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR} state_t;
    localparam logic [15:0] LP_MEM = 16'(MemSize);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t LP_TAIL = CHECK;
`else
    localparam state_t LP_TAIL = DONE;
`endif
    state_t          r_state, w_next;
    logic [7:0]      r_len_hi;
    logic [AW:0]     r_len;
    logic [AW:0]     r_words;
    logic [1:0]      r_bcnt;
    logic [size-9:0] r_word;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [size-1:0] r_wdata;
    logic [1:0]      r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif
    logic            w_xfer;
    logic            w_restart;
    logic [15:0]     w_n;
    logic [size-1:0] w_word;

    assign w_xfer       = in_valid && in_ready;
    assign w_restart    = load_req && (r_state == DONE || r_state == ERR);
    assign w_n          = {r_len_hi, in_data};
    assign w_word       = {r_word, in_data};
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign err_code     = r_err;
    assign words_loaded = r_words;

    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? LEN_HI : w_next;
    end

    // next-state: leave DATA only on the edge that ends the last write pulse
    always_comb begin
        w_next = r_state;
        case (r_state)
            LEN_HI:    if (w_xfer) w_next = LEN_LO;
            LEN_LO:    if (w_xfer) w_next = (w_n > LP_MEM) ? ERR : (w_n == 16'd0) ? LP_TAIL : DATA;
            DATA:      if (r_we && r_words == r_len) w_next = LP_TAIL;
`ifdef LOADER_CHECKSUM_EN
            CHECK:     if (w_xfer) w_next = (in_data == r_csum) ? DONE : ERR;
`endif
            DONE, ERR: if (load_req) w_next = LEN_HI;
            default:   w_next = LEN_HI;
        endcase
    end

    // outputs decoded from state and the registered write strobe only
    always_comb begin
        in_ready  = (r_state == LEN_HI || r_state == LEN_LO || r_state == DATA || r_state == CHECK) && !r_we;
        cpu_reset = r_state != DONE;
        done      = r_state == DONE;
    end

    // datapath: length capture, word assembly, write strobe, counters and error code
    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_len_hi <= 8'd0;
            r_len    <= '0;
            r_words  <= '0;
            r_bcnt   <= 2'd0;
            r_word   <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 2'b00;
`ifdef LOADER_CHECKSUM_EN
            r_csum   <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    LEN_HI: r_len_hi <= in_data;
                    LEN_LO: begin
                        r_len <= w_n[AW:0];
                        if (w_n > LP_MEM) r_err <= 2'b01;
                    end
                    DATA: begin
                        r_bcnt <= r_bcnt + 2'd1;
                        r_word <= w_word[size-9:0];
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        if (r_bcnt == 2'd3) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_word;
                            r_addr  <= r_words[AW-1:0];
                            r_words <= r_words + 1'b1;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: if (in_data != r_csum) r_err <= 2'b10;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed vectors with hand-computed expectations for program_loader
`timescale 1ns/1ps
module tb_program_loader;
    localparam int AW = 9;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          load_req = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready, imem_we, cpu_reset, done;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;
    int            n_tot = 0;
    int            n_bad = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .err_code(err_code), .words_loaded(words_loaded)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // record every write pulse; the CPU must still be held in reset while it is high
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            chk("we_cpu_reset", 32'(cpu_reset), 32'd1);
        end
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$], input bit gap);
        foreach (q[i]) begin
            send(q[i]);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20; i++) begin
            if (done || err_code != 2'b00) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic check_two_words(input string tag);
        chk({tag, "_n"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, 32'(wa[0]), 32'd0);
            chk({tag, "_d0"}, wd[0], 32'h12345678);
            chk({tag, "_a1"}, 32'(wa[1]), 32'd1);
            chk({tag, "_d1"}, wd[1], 32'h9ABCDEF0);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd2);
        chk({tag, "_err"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        logic [7:0] s_two[$];
        logic [7:0] s_one[$];
        s_two = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        s_one = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef LOADER_CHECKSUM_EN
        s_two.push_back(8'h00);
        s_one.push_back(8'h00);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;

        send_seq(s_two, 1'b0);
        wait_end();
        check_two_words("two");
        chk("two_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("done_hold", 32'(done), 32'd1);
        chk("done_hold_words", 32'(words_loaded), 32'd2);
        restart();
        chk("rl_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_in_ready", 32'(in_ready), 32'd1);
        chk("rl_words", 32'(words_loaded), 32'd0);

        wa.delete();
        wd.delete();
        send_seq('{8'h02, 8'h01}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_err", 32'(err_code), 32'd1);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_no_we", 32'(wa.size()), 32'd0);
        restart();
        chk("ovf_clear", 32'(err_code), 32'd0);

        send_seq('{8'h02, 8'h00}, 1'b0);
        chk("max_err", 32'(err_code), 32'd0);
        chk("max_in_ready", 32'(in_ready), 32'd1);
        chk("max_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        send_seq('{8'h00, 8'h00}, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        wait_end();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_words", 32'(words_loaded), 32'd0);
        chk("zero_no_we", 32'(wa.size()), 32'd0);
        restart();

        send_seq(s_two, 1'b1);
        wait_end();
        check_two_words("gap");
        restart();

        wa.delete();
        wd.delete();
        send_seq('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33}, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_words", 32'(words_loaded), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_we", 32'(wa.size()), 32'd0);
        send_seq(s_one, 1'b0);
        wait_end();
        chk("one_n", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("one_a0", 32'(wa[0]), 32'd0);
            chk("one_d0", wd[0], 32'hAABBCCDD);
        end
        chk("one_done", 32'(done), 32'd1);
        restart();
        chk("req_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("req_len_hi", 32'(in_ready), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        wa.delete();
        wd.delete();
        send_seq('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0);
        wait_end();
        chk("ck_bad_err", 32'(err_code), 32'd2);
        chk("ck_bad_words", 32'(words_loaded), 32'd1);
        chk("ck_bad_done", 32'(done), 32'd0);
        restart();
        send_seq('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 1'b0);
        wait_end();
        chk("ck_ok_done", 32'(done), 32'd1);
        chk("ck_ok_err", 32'(err_code), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter size, default 32, instruction word width in bits.
REQ-002 Parameter MemSize, default 512, instruction memory depth in words.
REQ-003 Parameter AW, default 9, instruction memory address width; MemSize SHALL be no greater than 2**AW.
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-007 in_data  input  8  program byte.
REQ-008 in_ready  output  1  loader accepts a byte; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-009 load_req  input  1  single-cycle request to restart loading; honoured in DONE or ERR only.
REQ-010 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-011 imem_addr  output  AW  instruction memory word address.
REQ-012 imem_wdata  output  size  instruction word to write.
REQ-013 cpu_reset  output  1  held-reset to the processor; 1 while loading.
REQ-014 done  output  1  load completed successfully.
REQ-015 err_code  output  2  00 none, 01 length overflow, 10 checksum mismatch.
REQ-016 words_loaded  output  AW+1  count of words written in the current load.

Function
REQ-017 Stream format SHALL be: length N as 2 bytes, big-endian; then N words of 4 bytes each, big-endian (first byte goes to bits 31:24).
REQ-018 The FSM SHALL have states LEN_HI, LEN_LO, DATA, CHECK, DONE and ERR.
REQ-019 LEN_HI SHALL go to LEN_LO when a byte is accepted.
REQ-020 On the LEN_LO byte, LEN_LO SHALL go to:
- ERR with err_code=01 if N>MemSize;
- CHECK if N=0 and the checksum feature is compiled in;
- DONE if N=0 and the checksum feature is compiled out;
- DATA otherwise.
REQ-021 In DATA, a 2-bit byte counter SHALL assemble each word.
- On the edge that accepts the 4th byte, the block SHALL register imem_we=1, imem_wdata=the assembled word, and imem_addr=the current word index.
- imem_we is therefore high in the cycle after that edge, for exactly one cycle.
REQ-022 The word index SHALL start at 0 and increment by 1 after each write; words_loaded SHALL equal the number of imem_we pulses issued.
REQ-023 After the Nth write pulse, the FSM SHALL move to CHECK, or to DONE if the checksum feature is compiled out. The move SHALL occur on the edge that ends the write pulse, so that cpu_reset never falls while imem_we=1.
REQ-024 in_ready SHALL be:
- 1 in LEN_HI, LEN_LO, DATA and CHECK;
- 0 in DONE and ERR;
- 0 in the cycle imem_we=1.
REQ-025 cpu_reset SHALL be 0 only in DONE; done SHALL be 1 only in DONE. Both SHALL be decoded from the state register with no combinational path from the inputs.
REQ-026 A load_req in DONE or ERR SHALL move the FSM to LEN_HI and clear err_code, words_loaded and the byte counter. cpu_reset SHALL rise on that same edge.
REQ-027 load_req in any other state SHALL be ignored.
REQ-028 Bytes presented while in_ready=0 SHALL not be consumed.
REQ-029 in_valid may drop between any two bytes; the partial word and the byte counter SHALL be held while it is low.

Reset
REQ-030 On reset the block SHALL set:
- state to LEN_HI, in_ready=1, cpu_reset=1;
- imem_we=0, imem_addr=0, imem_wdata=0;
- done=0, err_code=00, words_loaded=0;
- byte counter, word index, length register and checksum accumulator to 0.
REQ-031 Reset SHALL take priority over load_req and over any byte transfer in the same cycle.
REQ-032 A reset during DATA SHALL abandon the partial load; no write pulse SHALL follow.

Configuration
REQ-033 The macro LOADER_CHECKSUM_EN SHALL select the checksum feature.
- Defined: an 8-bit XOR accumulator SHALL cover every payload byte (length bytes excluded).
- Defined: CHECK SHALL accept one byte and go to DONE if it equals the accumulator, else to ERR with err_code=10.
- Not defined: CHECK SHALL be unreachable and no trailing byte is consumed.

Verification
REQ-034 Stream 00 02, 12 34 56 78, 9A BC DE F0 (with checksum byte 00 when enabled) -> two write pulses (addr 0 = 0x12345678, addr 1 = 0x9ABCDEF0), then done=1, cpu_reset=0, words_loaded=2.
REQ-035 Length 02 01 (513) with MemSize=512 -> ERR, err_code=01, no imem_we, in_ready=0, cpu_reset=1.
REQ-036 LOADER_CHECKSUM_EN defined, stream 00 01, 01 02 03 04, checksum byte 05 -> ERR with err_code=10 and words_loaded=1. Checksum byte 04 instead -> done=1.
REQ-037 Same stream as REQ-034 with in_valid toggling every other cycle -> identical words and addresses; no byte lost or duplicated.
REQ-038 Reset asserted after the 3rd data byte, then the stream 00 01, AA BB CC DD -> addr 0 = 0xAABBCCDD. load_req in DONE -> cpu_reset=1 and state LEN_HI on the next edge.
